// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arithmetic ops plus iterative radix-2 unsigned
// multiply and restoring divide behind a valid/ready request/result handshake.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_sub;
  logic             div_ge;

  assign sum  = data0 + data1;
  assign diff = data0 - data1;

  always_comb begin
    alu_res = sum;
    alu_ovf = (data0[WIDTH-1] == data1[WIDTH-1]) && (sum[WIDTH-1] != data0[WIDTH-1]);
    case (op)
      OP_AND:  begin alu_res = data0 & data1;    alu_ovf = 1'b0; end
      OP_OR:   begin alu_res = data0 | data1;    alu_ovf = 1'b0; end
      OP_NOR:  begin alu_res = ~(data0 | data1); alu_ovf = 1'b0; end
      OP_SLTU: begin
        alu_res = {{(WIDTH-1){1'b0}}, (data0 < data1)};
        alu_ovf = 1'b0;
      end
      OP_SLT:  begin
        alu_res = {{(WIDTH-1){1'b0}}, ($signed(data0) < $signed(data1))};
        alu_ovf = 1'b0;
      end
      OP_SUB:  begin
        alu_res = diff;
        alu_ovf = (data0[WIDTH-1] != data1[WIDTH-1]) && (diff[WIDTH-1] != data0[WIDTH-1]);
      end
      default: ; // OP_ADD and all unassigned codes
    endcase
  end

  // Multiply: {hi,lo} is the partial product, multiplier shifts out of lo.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: hi is the partial remainder, dividend shifts out of lo, quotient in.
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_sub = div_sh - {1'b0, opnd_q};
  assign div_ge  = (div_sh >= {1'b0, opnd_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          zero_d = 1'b0;
          if (op == OP_MULU) begin
            opnd_d  = data0;
            lo_d    = data1;
            hi_d    = '0;
            cnt_d   = CW'(WIDTH);
            state_d = MUL;
          end else if (op == OP_DIVU && data1 != '0) begin
            opnd_d  = data1;
            lo_d    = data0;
            hi_d    = '0;
            cnt_d   = CW'(WIDTH);
            state_d = DIV;
          end else if (op == OP_DIVU) begin
            lo_d    = '1;
            hi_d    = data0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            lo_d    = alu_res;
            hi_d    = '0;
            ovf_d   = alu_ovf;
            zero_d  = (alu_res == '0);
            state_d = DONE;
          end
        end
      end
      MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          zero_d  = (lo_d == '0);
          state_d = DONE;
        end
      end
      DIV: begin
        hi_d  = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          zero_d  = (lo_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign res_lo      = lo_q;
  assign res_hi      = hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] data0, data1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res_lo, res_hi;
  logic         zero, overflow, div_by_zero;

  int errors = 0;
  int checks = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data0(data0), .data1(data1), .out_valid(out_valid),
    .out_ready(out_ready), .res_lo(res_lo), .res_hi(res_hi), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         v;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request from a negedge and return the number of edges to out_valid.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_issue", in_ready, 1'b1);
    op = o; data0 = a; data1 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'b1100; data0 = $urandom; data1 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_consume", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; data0 = '0; data1 = '0;

    vecs[0]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'b0101, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33};
    vecs[11] = '{4'b1000, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 1'b0, 1'b0, 33};
    vecs[12] = '{4'b1000, 32'h00000000, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 33};
    vecs[13] = '{4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33};
    vecs[14] = '{4'b1001, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1};
    vecs[15] = '{4'b1001, 32'd5, 32'd10, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0, 33};
    vecs[16] = '{4'b1001, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 33};

    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", {out_valid, zero, overflow, div_by_zero, res_hi, res_lo}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_res_lo", i), res_lo, vecs[i].lo);
      chk($sformatf("v%0d_res_hi", i), res_hi, vecs[i].hi);
      chk($sformatf("v%0d_flags_zvd", i), {zero, overflow, div_by_zero},
          {vecs[i].z, vecs[i].v, vecs[i].dz});
      consume();
    end

    // Stall in DONE with new requests presented: nothing may change.
    run_op(4'b0010, 32'd3, 32'd4, lat);
    chk("stall_latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'b0001; data0 = 32'h100 + i; data1 = 32'h1;
      @(negedge clk);
      chk($sformatf("stall%0d_hold", i), {out_valid, in_ready, zero, overflow, res_hi, res_lo},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd7});
    end
    // Request held through the consume edge is taken only once back in IDLE.
    op = 4'b0001; data0 = 32'h0F; data1 = 32'hF0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("no_accept_on_consume", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept_after_consume", {out_valid, res_lo}, {1'b1, 32'hFF});
    consume();

    // Reset in the middle of a multiply.
    op = 4'b1000; data0 = 32'd3; data1 = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", in_ready, 1'b1);
    chk("midreset_outputs", {out_valid, zero, overflow, div_by_zero, res_hi, res_lo}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b0010, 32'd10, 32'd20, lat);
    chk("post_reset_latency", lat, 1);
    chk("post_reset_res", {res_hi, res_lo}, {32'd0, 32'd30});
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
